// File: rtl/sim_monitor.sv
// sim_monitor: counts CPU cycles until halt or timeout, then stalls the CPU and streams the register file out one record at a time.
module sim_monitor #(
  parameter int                RWIDTH  = 16,
  parameter int                NREGS   = 16,
  parameter int                IWIDTH  = 16,
  parameter logic [IWIDTH-1:0] HALT_IR = 16'hFFFF,
  parameter int                CWIDTH  = 16,
  parameter int                TIMEOUT = 1000,
  localparam int               SW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              clear_i,
  input  logic [IWIDTH-1:0] ir_i,
  output logic [SW-1:0]     reg_sel_o,
  input  logic [RWIDTH-1:0] reg_data_i,
  output logic              cpu_stall_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [SW-1:0]     dump_idx_o,
  output logic [RWIDTH-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [CWIDTH-1:0] cycles_o
);
  typedef enum logic [1:0] {RUN, FETCH, SEND, DONE} state_t;
  state_t            r_state, w_next;
  logic [CWIDTH-1:0] r_cycles;
  logic [SW-1:0]     r_idx, r_didx;
  logic [RWIDTH-1:0] r_data;
  logic [1:0]        r_status;
  logic              w_halt, w_tmo, w_hs, w_last_idx;
  assign w_halt     = r_state == RUN && enable_i && ir_i == HALT_IR;
  assign w_tmo      = r_state == RUN && enable_i && r_cycles == CWIDTH'(TIMEOUT);
  assign w_hs       = r_state == SEND && dump_ready_i;
  assign w_last_idx = r_idx == SW'(NREGS - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      RUN:   w_next = (w_halt || w_tmo) ? FETCH : RUN;
      FETCH: w_next = SEND;
      SEND:  w_next = w_hs ? (w_last_idx ? DONE : FETCH) : SEND;
      DONE:  w_next = clear_i ? RUN : DONE;
      default: w_next = RUN;
    endcase
  end
  // The counter freezes on the detecting cycle so it reports the cycle at which the run ended.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= RUN;
      r_cycles <= '0;
      r_idx    <= '0;
      r_didx   <= '0;
      r_data   <= '0;
      r_status <= 2'b00;
    end else begin
      r_state <= w_next;
      if (r_state == RUN && enable_i && !w_halt && !w_tmo) r_cycles <= r_cycles + CWIDTH'(1);
      if (r_state == DONE && clear_i) begin
        r_cycles <= '0;
        r_status <= 2'b00;
      end
      if (w_halt) r_status <= 2'b01;
      else if (w_tmo) r_status <= 2'b10;
      if (w_halt || w_tmo) r_idx <= '0;
      else if (w_hs && !w_last_idx) r_idx <= r_idx + SW'(1);
      if (r_state == FETCH) begin
        r_data <= reg_data_i;
        r_didx <= r_idx;
      end
    end
  end
  assign reg_sel_o    = r_idx;
  assign cpu_stall_o  = r_state != RUN;
  assign dump_valid_o = r_state == SEND;
  assign dump_idx_o   = r_didx;
  assign dump_data_o  = r_data;
  assign dump_last_o  = r_state == SEND && r_didx == SW'(NREGS - 1);
  assign done_o       = r_state == DONE;
  assign status_o     = r_status;
  assign cycles_o     = r_cycles;
endmodule

// File: tb/tb_sim_monitor.sv
// tb_sim_monitor: directed checks of halt, timeout, backpressure, clear and async-reset abort on sim_monitor.
module tb_sim_monitor;
  logic        clk = 0, reset, enable_i, clear_i, dump_ready_i;
  logic [15:0] ir_i, reg_data_i, dump_data_o, cycles_o;
  logic [3:0]  reg_sel_o, dump_idx_o;
  logic        cpu_stall_o, dump_valid_o, dump_last_o, done_o;
  logic [1:0]  status_o;
  int          total = 0, bad = 0, nrec, ncyc;
  sim_monitor dut (
    .clk(clk), .reset(reset), .enable_i(enable_i), .clear_i(clear_i), .ir_i(ir_i),
    .reg_sel_o(reg_sel_o), .reg_data_i(reg_data_i), .cpu_stall_o(cpu_stall_o),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_idx_o(dump_idx_o),
    .dump_data_o(dump_data_o), .dump_last_o(dump_last_o), .done_o(done_o),
    .status_o(status_o), .cycles_o(cycles_o)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] regval(input logic [3:0] i);
    return {i, ~i, i, 4'h3} ^ 16'h5A00;
  endfunction
  assign reg_data_i = regval(reg_sel_o);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_cyc(input int v);
    for (int k = 0; k < 2000 && cycles_o != 16'(v); k++) @(negedge clk);
    chk("wait_cycles", 32'(cycles_o), 32'(v));
  endtask
  task automatic halt_now();
    ir_i = 16'hFFFF;
    @(negedge clk);
    ir_i = 16'h0;
  endtask
  task automatic clear_done();
    clear_i = 1;
    @(negedge clk);
    clear_i = 0;
    chk("clr_cycles", 32'(cycles_o), 0);
    chk("clr_status", 32'(status_o), 0);
    chk("clr_done", 32'(done_o), 0);
    chk("clr_stall", 32'(cpu_stall_o), 0);
  endtask
  // Called at the negedge right after the halt/timeout edge; returns records accepted and cycles until DONE.
  task automatic collect(input bit bp, input bit clr, output int nr, output int nc);
    logic pv, pr, plast;
    logic [3:0] pidx;
    logic [15:0] pdata;
    pv = 0; pr = 0; plast = 0; pidx = 0; pdata = 0; nr = 0; nc = -1;
    for (int n = 0; n < 3000; n++) begin
      if (pv && pr) begin
        chk("rec_idx", 32'(pidx), 32'(nr));
        chk("rec_data", 32'(pdata), 32'(regval(pidx)));
        chk("rec_last", 32'(plast), 32'(pidx == 4'd15));
        chk("fetch_novalid", 32'(dump_valid_o), 0);
        nr++;
      end else if (pv) begin
        chk("hold_valid", 32'(dump_valid_o), 1);
        chk("hold_idx", 32'(dump_idx_o), 32'(pidx));
        chk("hold_data", 32'(dump_data_o), 32'(pdata));
        chk("hold_last", 32'(dump_last_o), 32'(plast));
      end
      if (done_o) begin
        nc = n;
        dump_ready_i = 0;
        clear_i = 0;
        return;
      end
      pv = dump_valid_o; pidx = dump_idx_o; pdata = dump_data_o; plast = dump_last_o;
      pr = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      dump_ready_i = pr;
      clear_i = clr;
      @(negedge clk);
    end
    chk("collect_timeout", 0, 1);
    dump_ready_i = 0;
    clear_i = 0;
  endtask
  initial begin
    reset = 1; enable_i = 0; clear_i = 0; ir_i = 0; dump_ready_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_cycles", 32'(cycles_o), 0);
    chk("rst_status", 32'(status_o), 0);
    chk("rst_valid", 32'(dump_valid_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_stall", 32'(cpu_stall_o), 0);
    chk("rst_data", 32'(dump_data_o), 0);
    reset = 0; enable_i = 1;
    @(negedge clk);
    chk("count1", 32'(cycles_o), 1);
    enable_i = 0; ir_i = 16'hFFFF;
    repeat (3) @(negedge clk);
    chk("dis_cycles", 32'(cycles_o), 1);
    chk("dis_status", 32'(status_o), 0);
    chk("dis_stall", 32'(cpu_stall_o), 0);
    enable_i = 1; ir_i = 0;
    wait_cyc(5);
    halt_now();
    chk("halt_status", 32'(status_o), 1);
    chk("halt_cycles", 32'(cycles_o), 5);
    chk("halt_stall", 32'(cpu_stall_o), 1);
    chk("halt_fetch_novalid", 32'(dump_valid_o), 0);
    collect(0, 0, nrec, ncyc);
    chk("halt_nrec", 32'(nrec), 16);
    chk("halt_ncyc", 32'(ncyc), 32);
    chk("halt_done", 32'(done_o), 1);
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(done_o), 1);
    chk("done_cycles", 32'(cycles_o), 5);
    chk("done_status", 32'(status_o), 1);
    chk("done_stall", 32'(cpu_stall_o), 1);
    clear_done();
    wait_cyc(1000);
    @(negedge clk);
    chk("tmo_status", 32'(status_o), 2);
    chk("tmo_cycles", 32'(cycles_o), 1000);
    chk("tmo_stall", 32'(cpu_stall_o), 1);
    collect(1, 1, nrec, ncyc);
    chk("tmo_nrec", 32'(nrec), 16);
    chk("tmo_done", 32'(done_o), 1);
    chk("tmo_status_done", 32'(status_o), 2);
    clear_done();
    wait_cyc(1000);
    halt_now();
    chk("both_status", 32'(status_o), 1);
    chk("both_cycles", 32'(cycles_o), 1000);
    collect(0, 0, nrec, ncyc);
    chk("both_nrec", 32'(nrec), 16);
    clear_done();
    wait_cyc(3);
    halt_now();
    dump_ready_i = 1;
    for (int k = 0; k < 100 && !(dump_valid_o && dump_idx_o == 4'd7); k++) @(negedge clk);
    dump_ready_i = 0;
    chk("abort_at_idx7", 32'(dump_idx_o), 7);
    chk("abort_valid", 32'(dump_valid_o), 1);
    #2 reset = 1;
    #1;
    chk("arst_valid", 32'(dump_valid_o), 0);
    chk("arst_last", 32'(dump_last_o), 0);
    chk("arst_done", 32'(done_o), 0);
    chk("arst_stall", 32'(cpu_stall_o), 0);
    chk("arst_status", 32'(status_o), 0);
    chk("arst_cycles", 32'(cycles_o), 0);
    chk("arst_idx", 32'(dump_idx_o), 0);
    chk("arst_data", 32'(dump_data_o), 0);
    chk("arst_sel", 32'(reg_sel_o), 0);
    #1 reset = 0;
    @(negedge clk);
    chk("post_rst_cycles", 32'(cycles_o), 1);
    chk("post_rst_valid", 32'(dump_valid_o), 0);
    wait_cyc(4);
    halt_now();
    chk("redump_status", 32'(status_o), 1);
    collect(1, 0, nrec, ncyc);
    chk("redump_nrec", 32'(nrec), 16);
    chk("redump_done", 32'(done_o), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sim_monitor.md
SIM_MONITOR -- requirements
Module: sim_monitor

Interface
REQ-001 SHALL provide parameters:
- RWIDTH, default 16, register data width.
- NREGS, default 16, registers dumped; power of two, 2..256.
- IWIDTH, default 16, instruction width.
- HALT_IR, default 16'hFFFF, halt opcode.
- CWIDTH, default 16, cycle counter width.
- TIMEOUT, default 1000, cycle limit; must be less than 2^CWIDTH.
REQ-002 SHALL provide ports (SW = log2(NREGS)):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- enable_i  in  1  count and monitor enable.
- clear_i  in  1  rearm from DONE.
- ir_i  in  IWIDTH  CPU current instruction.
- reg_sel_o  out  SW  register-file read select.
- reg_data_i  in  RWIDTH  combinational read data for reg_sel_o.
- cpu_stall_o  out  1  holds CPU while not RUN.
- dump_valid_o  out  1  dump record valid.
- dump_ready_i  in  1  sink accepts record.
- dump_idx_o  out  SW  register index of record.
- dump_data_o  out  RWIDTH  register value.
- dump_last_o  out  1  final record.
- done_o  out  1  dump complete.
- status_o  out  2  00 run, 01 halted, 10 timeout.
- cycles_o  out  CWIDTH  elapsed enabled cycles.
REQ-003 SHALL use one clock, clk; reset SHALL be asynchronous and active-high, named reset.

Function
REQ-004 SHALL implement states RUN, FETCH, SEND, DONE.
REQ-005 In RUN, cycles_o SHALL increment by 1 each enabled cycle (enable_i=1); outside RUN, or with enable_i=0, it SHALL hold.
REQ-006 In RUN with enable_i=1:
- ir_i==HALT_IR: status_o:=01, index:=0, go FETCH.
- Else if cycles_o==TIMEOUT: status_o:=10, index:=0, go FETCH.
- Both in the same cycle: halt wins.
REQ-007 With enable_i=0, no halt or timeout detection SHALL occur.
REQ-008 cpu_stall_o SHALL be 1 in every state except RUN, asserted from the first FETCH cycle.
REQ-009 FETCH SHALL last exactly one cycle: reg_sel_o=index; register reg_data_i into dump_data_o and index into dump_idx_o; go SEND.
REQ-010 In SEND, dump_valid_o SHALL be 1, and dump_data_o, dump_idx_o and dump_last_o SHALL hold stable until the cycle dump_ready_i=1.
REQ-011 On handshake (valid&ready):
- index==NREGS-1: go DONE.
- Else: index+1, go FETCH.
- Minimum 2 cycles per record; NREGS records total, indices 0..NREGS-1 ascending.
REQ-012 dump_last_o SHALL be 1 only while SEND presents index NREGS-1.
REQ-013 dump_valid_o SHALL be 0 in RUN, FETCH and DONE.
REQ-014 In DONE, done_o SHALL be 1, status_o and cycles_o SHALL hold, and clear_i SHALL be ignored in every other state.
REQ-015 clear_i=1 in DONE SHALL return to RUN next cycle with cycles_o=0, status_o=00, done_o=0.
REQ-016 reg_sel_o SHALL equal the index register in all states; index SHALL never exceed NREGS-1.

Reset
REQ-017 Assertion of reset SHALL, without waiting for clk:
- set state to RUN;
- clear cycles_o, index, dump_data_o, dump_idx_o and status_o;
- drive dump_valid_o, dump_last_o, done_o and cpu_stall_o to 0.
REQ-018 Reset during FETCH/SEND SHALL abort the dump immediately with no further records; after release, counting restarts from 0.

Verification
REQ-019 Bench SHALL cover:
- Defaults, enable_i=1, ir_i=HALT_IR at cycles_o=5 with dump_ready_i=1 -> status_o=01, cycles_o holds 5, 16 records idx 0..15 matching the register file, dump_last_o only on idx 15, done_o=1 after 32 cycles.
- ir_i never HALT_IR -> at cycles_o=1000, status_o=10, stall asserted, full dump, done_o=1.
- Random dump_ready_i backpressure -> valid never drops and data/idx never change before handshake; no record lost or duplicated.
- Halt and timeout in the same cycle (ir_i=HALT_IR when cycles_o=1000) -> status_o=01.
- Reset pulse during SEND of idx 7 -> all outputs 0 immediately; next halt dumps from idx 0.
- clear_i in DONE -> RUN with cycles_o=0; clear_i during SEND -> no effect; second halt produces a full second dump.
